// File: rtl/bcd_counter_ctl.sv
// bcd_counter_ctl: run/pause/clear 4-digit BCD up/down counter with tick
// prescaler, saturating wrap counter and pushbutton-driven display mode flag.
module bcd_counter_ctl #(
  parameter int unsigned TICK_DIV      = 50000000,
  parameter int unsigned CNT_W         = 26,
  parameter int unsigned BCD_BIT_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     btn_start,
  input  logic                     btn_mode,
  input  logic                     btn_clear,
  input  logic                     up_down,
  output logic [BCD_BIT_WIDTH-1:0] bcd0,
  output logic [BCD_BIT_WIDTH-1:0] bcd1,
  output logic [BCD_BIT_WIDTH-1:0] bcd2,
  output logic [BCD_BIT_WIDTH-1:0] bcd3,
  output logic [3:0]               counter_num,
  output logic                     mode_selection,
  output logic                     running
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  state_t                   state;
  logic [CNT_W-1:0]         prescaler;
  logic                     start_q, mode_q;
  logic                     start_p, mode_p;
  logic                     tick;
  logic [BCD_BIT_WIDTH-1:0] dig  [4];
  logic [BCD_BIT_WIDTH-1:0] nxt  [4];
  logic                     wrap;

  assign bcd0 = dig[0];
  assign bcd1 = dig[1];
  assign bcd2 = dig[2];
  assign bcd3 = dig[3];

  // One count tick on the last prescaler cycle while running
  always_comb begin
    tick = (state == RUN) && (prescaler == CNT_W'(TICK_DIV - 1));
  end

  // Ripple the increment/decrement from the units digit (index 3) upward;
  // a carry/borrow surviving past the thousands digit marks a wrap.
  always_comb begin
    wrap = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      nxt[i] = dig[i];
    end
    for (int unsigned k = 0; k < 4; k++) begin
      if (wrap) begin
        if (up_down) begin
          if (dig[3-k] == BCD_BIT_WIDTH'(9)) begin
            nxt[3-k] = '0;
          end else begin
            nxt[3-k] = dig[3-k] + 1'b1;
            wrap     = 1'b0;
          end
        end else begin
          if (dig[3-k] == '0) begin
            nxt[3-k] = BCD_BIT_WIDTH'(9);
          end else begin
            nxt[3-k] = dig[3-k] - 1'b1;
            wrap     = 1'b0;
          end
        end
      end
    end
  end

  // Edge detect, mode toggle, prescaler, FSM and digit registers.
  // The button pulses are registered so the FSM and mode flag react on the
  // edge after the one that first samples the rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      prescaler      <= '0;
      start_q        <= 1'b0;
      mode_q         <= 1'b0;
      start_p        <= 1'b0;
      mode_p         <= 1'b0;
      counter_num    <= '0;
      mode_selection <= 1'b0;
      running        <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) dig[i] <= '0;
    end else begin
      start_q <= btn_start;
      mode_q  <= btn_mode;
      start_p <= btn_start & ~start_q;
      mode_p  <= btn_mode & ~mode_q;

      if (mode_p) mode_selection <= ~mode_selection;

      if (btn_clear) begin
        state       <= IDLE;
        running     <= 1'b0;
        prescaler   <= '0;
        counter_num <= '0;
        for (int unsigned i = 0; i < 4; i++) dig[i] <= '0;
      end else begin
        case (state)
          IDLE: begin
            prescaler   <= '0;
            counter_num <= '0;
            for (int unsigned i = 0; i < 4; i++) dig[i] <= '0;
            if (start_p) begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
          RUN: begin
            if (tick) begin
              prescaler <= '0;
              for (int unsigned i = 0; i < 4; i++) dig[i] <= nxt[i];
              if (wrap && counter_num != 4'd9) counter_num <= counter_num + 4'd1;
            end else begin
              prescaler <= prescaler + 1'b1;
            end
            if (start_p) begin
              state   <= PAUSE;
              running <= 1'b0;
            end
          end
          PAUSE: begin
            if (start_p) begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
          default: begin
            state   <= IDLE;
            running <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bcd_counter_ctl.sv
// Testbench for bcd_counter_ctl: constant vector table, directed corner
// sequences and randomized stimulus against an integer-valued reference model.
module tb_bcd_counter_ctl;

  localparam int unsigned TICK_DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_start = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_clear = 1'b0;
  logic       up_down = 1'b1;
  logic [3:0] bcd0, bcd1, bcd2, bcd3;
  logic [3:0] counter_num;
  logic       mode_selection;
  logic       running;

  int n_checks = 0;
  int n_errors = 0;

  bcd_counter_ctl #(.TICK_DIV(TICK_DIV), .CNT_W(3), .BCD_BIT_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .btn_start(btn_start), .btn_mode(btn_mode),
    .btn_clear(btn_clear), .up_down(up_down),
    .bcd0(bcd0), .bcd1(bcd1), .bcd2(bcd2), .bcd3(bcd3),
    .counter_num(counter_num), .mode_selection(mode_selection), .running(running)
  );

  always #5 clk = ~clk;

  // {running, mode_selection, counter_num, thousands..units}
  logic [21:0] dut_vec;
  assign dut_vec = {running, mode_selection, counter_num, bcd0, bcd1, bcd2, bcd3};

  // Reference model: count value as an integer 0..9999
  int m_val, m_wraps, m_pre;
  bit m_mode, m_active, m_run;
  bit m_prev_s, m_prev_m, m_pend_s, m_pend_m;

  function automatic void model_count(bit u);
    bit w;
    w = 1'b0;
    if (u) begin
      if (m_val == 9999) begin m_val = 0; w = 1'b1; end
      else m_val = m_val + 1;
    end else begin
      if (m_val == 0) begin m_val = 9999; w = 1'b1; end
      else m_val = m_val - 1;
    end
    if (w && m_wraps < 9) m_wraps = m_wraps + 1;
  endfunction

  function automatic void model_update(bit r, bit s, bit m, bit c, bit u);
    bit ns, nm, tk;
    if (r) begin
      m_val = 0; m_wraps = 0; m_pre = 0; m_mode = 0; m_active = 0; m_run = 0;
      m_prev_s = 0; m_prev_m = 0; m_pend_s = 0; m_pend_m = 0;
      return;
    end
    ns = s && !m_prev_s;
    nm = m && !m_prev_m;
    if (m_pend_m) m_mode = !m_mode;
    if (c) begin
      m_val = 0; m_wraps = 0; m_pre = 0; m_active = 0; m_run = 0;
    end else if (!m_active) begin
      m_val = 0; m_wraps = 0; m_pre = 0;
      if (m_pend_s) begin m_active = 1; m_run = 1; end
    end else if (m_run) begin
      tk = (m_pre == int'(TICK_DIV) - 1);
      m_pre = tk ? 0 : m_pre + 1;
      if (tk) model_count(u);
      if (m_pend_s) m_run = 0;
    end else if (m_pend_s) begin
      m_run = 1;
    end
    m_prev_s = s; m_prev_m = m; m_pend_s = ns; m_pend_m = nm;
  endfunction

  function automatic logic [21:0] model_vec();
    logic [15:0] d;
    d = {4'(m_val / 1000), 4'((m_val / 100) % 10), 4'((m_val / 10) % 10), 4'(m_val % 10)};
    return {m_run, m_mode, 4'(m_wraps), d};
  endfunction

  task automatic check(input string name, input logic [21:0] got, input logic [21:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got run/mode/cnt/digits=%0h expected %0h", name, got, exp);
    end
  endtask

  task automatic drive(input bit r, input bit s, input bit m, input bit c, input bit u);
    rst = r; btn_start = s; btn_mode = m; btn_clear = c; up_down = u;
    @(posedge clk);
    model_update(r, s, m, c, u);
    #1;
  endtask

  // Hold inputs for n cycles, comparing against the model after each edge
  task automatic run_cycles(input int n, input bit s, input bit m, input bit c, input bit u,
                            input string name);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, s, m, c, u);
      check(name, dut_vec, model_vec());
    end
  endtask

  typedef struct {
    bit          r, s, m, c, u;
    bit          e_run, e_mode;
    logic [3:0]  e_cnt;
    logic [15:0] e_dig;
  } vec_t;

  vec_t vecs [13];

  bit rs, rm, ru, rc, rr;

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0000};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0000};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 16'h0000};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 16'h0000};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 16'h0000};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 16'h0000};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 16'h0001};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 16'h0001};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'd0, 16'h0001};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'd0, 16'h0001};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd0, 16'h0002};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 16'h0000};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 16'h0000};

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].r, vecs[i].s, vecs[i].m, vecs[i].c, vecs[i].u);
      check($sformatf("vec%0d", i), dut_vec,
            {vecs[i].e_run, vecs[i].e_mode, vecs[i].e_cnt, vecs[i].e_dig});
    end

    // Start, then 40 cycles of RUN: ten ticks reach 0010
    run_cycles(2, 1'b1, 1'b0, 1'b0, 1'b1, "start");
    check("start_running", dut_vec, {1'b1, 1'b1, 4'd0, 16'h0000});
    run_cycles(40, 1'b0, 1'b0, 1'b0, 1'b1, "run40");
    check("tens_carry", dut_vec, {1'b1, 1'b1, 4'd0, 16'h0010});

    // Wraps in both directions and counter_num saturation
    run_cycles(1, 1'b0, 1'b0, 1'b1, 1'b1, "clr");
    run_cycles(2, 1'b1, 1'b0, 1'b0, 1'b1, "start2");
    run_cycles(4, 1'b0, 1'b0, 1'b0, 1'b0, "down_wrap");
    check("down_wrap_9999", dut_vec, {1'b1, 1'b1, 4'd1, 16'h9999});
    run_cycles(4, 1'b0, 1'b0, 1'b0, 1'b1, "up_wrap");
    check("up_wrap_0000", dut_vec, {1'b1, 1'b1, 4'd2, 16'h0000});
    for (int k = 0; k < 10; k++) run_cycles(4, 1'b0, 1'b0, 1'b0, 1'(k % 2), "wraps");
    check("wrap_saturate", dut_vec, {1'b1, 1'b1, 4'd9, 16'h0000});
    run_cycles(4, 1'b0, 1'b0, 1'b0, 1'b1, "post_sat");
    check("count_after_sat", dut_vec, {1'b1, 1'b1, 4'd9, 16'h0001});

    // Pause holds digits and prescaler; resume ticks two edges later
    run_cycles(1, 1'b0, 1'b0, 1'b1, 1'b1, "clr2");
    run_cycles(2, 1'b1, 1'b0, 1'b0, 1'b1, "start3");
    run_cycles(20, 1'b0, 1'b0, 1'b0, 1'b1, "to_5");
    run_cycles(2, 1'b1, 1'b0, 1'b0, 1'b1, "pause");
    check("paused", dut_vec, {1'b0, 1'b1, 4'd0, 16'h0005});
    run_cycles(20, 1'b0, 1'b0, 1'b0, 1'b1, "hold");
    check("pause_hold", dut_vec, {1'b0, 1'b1, 4'd0, 16'h0005});
    run_cycles(2, 1'b1, 1'b0, 1'b0, 1'b1, "resume");
    check("resumed", dut_vec, {1'b1, 1'b1, 4'd0, 16'h0005});
    run_cycles(1, 1'b0, 1'b0, 1'b0, 1'b1, "resume1");
    check("resume_pre3", dut_vec, {1'b1, 1'b1, 4'd0, 16'h0005});
    run_cycles(1, 1'b0, 1'b0, 1'b0, 1'b1, "resume2");
    check("resume_tick", dut_vec, {1'b1, 1'b1, 4'd0, 16'h0006});

    // Clear and start rising together while running: clear wins
    run_cycles(3, 1'b1, 1'b0, 1'b1, 1'b1, "clr_start");
    check("clear_wins", dut_vec, {1'b0, 1'b1, 4'd0, 16'h0000});
    run_cycles(1, 1'b0, 1'b0, 1'b0, 1'b1, "clr_release");
    check("stays_idle", dut_vec, {1'b0, 1'b1, 4'd0, 16'h0000});

    // Reset mid-run clears everything, including mode; no ticks afterwards
    run_cycles(2, 1'b1, 1'b0, 1'b0, 1'b1, "start4");
    run_cycles(24, 1'b0, 1'b0, 1'b0, 1'b0, "run_down");
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("mid_reset", dut_vec, 22'h0);
    run_cycles(12, 1'b0, 1'b0, 1'b0, 1'b1, "post_reset");
    check("no_tick_after_reset", dut_vec, 22'h0);

    // Randomized stimulus against the model
    rs = 0; rm = 0; ru = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) rs = !rs;
      if ($urandom_range(0, 15) == 0) rm = !rm;
      if ($urandom_range(0, 7) == 0)  ru = !ru;
      rc = ($urandom_range(0, 99) == 0);
      rr = ($urandom_range(0, 499) == 0);
      drive(rr, rs, rm, rc, ru);
      check("random", dut_vec, model_vec());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
